// File: rtl/lifo_ctl.sv
// lifo_ctl: parametrised LIFO stack with top/next-on-stack read ports,
// occupancy count, full/empty flags and sticky overflow/underflow flags.
// Optional build macro LIFO_HIWATER_EN adds a high-water-mark register on
// o_hiwater; without it o_hiwater is tied to 0.
module lifo_ctl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic [CW-1:0]    o_hiwater
);

    // Index width for the storage array; DEPTH >= 2 keeps this >= 1.
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [CW-1:0]    sp_dec;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    nos_idx;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    wr_idx;
    logic             wr_en;
    logic             ovf_set;
    logic             unf_set;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    op_e              op;

    assign op       = op_e'({i_push, i_pop});
    assign empty    = (sp == '0);
    assign full     = (sp == CW'(DEPTH));
    assign sp_dec   = sp - CW'(1);
    assign top_idx  = sp_dec[IW-1:0];
    assign nos_idx  = top_idx - IW'(1);
    assign push_idx = sp[IW-1:0];

    // Decode the requested operation against the bounds before any update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = push_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!i_rst) begin
            unique case (op)
                OP_IDLE: ;
                OP_PUSH: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = push_idx;
                        sp_next = sp + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        sp_next = sp_dec;
                    end
                end
                OP_REPLACE: begin
                    // Overwrites the top in place, so it is legal even when full.
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = top_idx;
                    end
                end
            endcase
        end
    end

    // Storage write port; slot contents survive reset because reads are masked by sp.
    always_ff @(posedge i_clk) begin
        // NOTE: the array has no reset on purpose; unoccupied slots are never visible.
        if (wr_en) begin
            mem[wr_idx] <= i_data;
        end
    end

    // Stack pointer and sticky error flags, synchronous reset has priority.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef LIFO_HIWATER_EN
    logic [CW-1:0] hiwater;

    // High-water mark tracks the largest occupancy seen since reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hiwater <= '0;
        end else if (sp_next > hiwater) begin
            hiwater <= sp_next;
        end
    end

    assign o_hiwater = hiwater;
`else
    assign o_hiwater = '0;
`endif

    assign o_s0        = empty ? '0 : mem[top_idx];
    assign o_s1        = (sp < CW'(2)) ? '0 : mem[nos_idx];
    assign o_count     = sp;
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_overflow  = overflow;
    assign o_underflow = underflow;

endmodule

// File: tb/tb_lifo_ctl.sv
// tb_lifo_ctl: directed plus random stimulus for lifo_ctl (WIDTH=16, DEPTH=4).
// A behavioural stack model produces expected outputs which are queued at
// drive time and compared one cycle later; the documented scenarios also get
// literal spot checks. Honours LIFO_HIWATER_EN for the o_hiwater expectation.
module tb_lifo_ctl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_push = 1'b0;
    logic             i_pop = 1'b0;
    logic [WIDTH-1:0] o_s0;
    logic [WIDTH-1:0] o_s1;
    logic [CW-1:0]    o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_overflow;
    logic             o_underflow;
    logic [CW-1:0]    o_hiwater;

    lifo_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .o_s0        (o_s0),
        .o_s1        (o_s1),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_hiwater   (o_hiwater)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [WIDTH-1:0] s0;
        logic [WIDTH-1:0] s1;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
        logic [CW-1:0]    hw;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_sp  = 0;
    int               m_hw  = 0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

`ifdef LIFO_HIWATER_EN
    localparam int HW_EXPECT = 3;
`else
    localparam int HW_EXPECT = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_update(input logic rst, input logic push, input logic pop,
                                input logic [WIDTH-1:0] data);
        if (rst) begin
            m_sp  = 0;
            m_hw  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (push && !pop) begin
                if (m_sp == DEPTH) m_ovf = 1'b1;
                else begin
                    m_mem[m_sp] = data;
                    m_sp++;
                end
            end else if (!push && pop) begin
                if (m_sp == 0) m_unf = 1'b1;
                else m_sp--;
            end else if (push && pop) begin
                if (m_sp == 0) m_unf = 1'b1;
                else m_mem[m_sp-1] = data;
            end
`ifdef LIFO_HIWATER_EN
            if (m_sp > m_hw) m_hw = m_sp;
`endif
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.s0    = (m_sp > 0) ? m_mem[m_sp-1] : '0;
        e.s1    = (m_sp > 1) ? m_mem[m_sp-2] : '0;
        e.count = CW'(m_sp);
        e.empty = (m_sp == 0);
        e.full  = (m_sp == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.hw    = CW'(m_hw);
        return e;
    endfunction

    // One operation: drive, queue the expectation, clock, then pop and compare.
    task automatic step(input string tag, input logic rst, input logic push,
                        input logic pop, input logic [WIDTH-1:0] data);
        exp_t  e;
        string t;
        i_rst  = rst;
        i_push = push;
        i_pop  = pop;
        i_data = data;
        model_update(rst, push, pop, data);
        sb.push_back(model_expect());
        sb_tag.push_back(tag);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check({t, ".s0"},    32'(o_s0),        32'(e.s0));
        check({t, ".s1"},    32'(o_s1),        32'(e.s1));
        check({t, ".count"}, 32'(o_count),     32'(e.count));
        check({t, ".empty"}, 32'(o_empty),     32'(e.empty));
        check({t, ".full"},  32'(o_full),      32'(e.full));
        check({t, ".ovf"},   32'(o_overflow),  32'(e.ovf));
        check({t, ".unf"},   32'(o_underflow), 32'(e.unf));
        check({t, ".hw"},    32'(o_hiwater),   32'(e.hw));
    endtask

    initial begin
        // Reset state.
        step("reset", 1'b1, 1'b0, 1'b0, '0);
        check("rst_s0", 32'(o_s0), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);

        // Push 13, push 21, pop.
        step("push13", 1'b0, 1'b1, 1'b0, 16'd13);
        step("push21", 1'b0, 1'b1, 1'b0, 16'd21);
        check("p21_s0", 32'(o_s0), 32'd21);
        check("p21_s1", 32'(o_s1), 32'd13);
        check("p21_count", 32'(o_count), 32'd2);
        step("pop1", 1'b0, 1'b0, 1'b1, '0);
        check("pop1_s0", 32'(o_s0), 32'd13);
        check("pop1_s1", 32'(o_s1), 32'd0);
        check("pop1_count", 32'(o_count), 32'd1);

        // Replace, then push 55, 89.
        step("rep34", 1'b0, 1'b1, 1'b1, 16'd34);
        check("rep34_s0", 32'(o_s0), 32'd34);
        check("rep34_count", 32'(o_count), 32'd1);
        step("push55", 1'b0, 1'b1, 1'b0, 16'd55);
        step("push89", 1'b0, 1'b1, 1'b0, 16'd89);
        check("p89_s0", 32'(o_s0), 32'd89);
        check("p89_s1", 32'(o_s1), 32'd55);
        check("p89_count", 32'(o_count), 32'd3);

        // Fill, overflow, replace at full, pop out of full.
        step("reset2", 1'b1, 1'b0, 1'b0, '0);
        for (int v = 1; v <= 4; v++) step("fill", 1'b0, 1'b1, 1'b0, 16'(v));
        check("fill_full", 32'(o_full), 32'd1);
        step("push5_ovf", 1'b0, 1'b1, 1'b0, 16'd5);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_s0", 32'(o_s0), 32'd4);
        check("ovf_count", 32'(o_count), 32'd4);
        step("rep7_full", 1'b0, 1'b1, 1'b1, 16'd7);
        check("rep7_s0", 32'(o_s0), 32'd7);
        check("rep7_full", 32'(o_full), 32'd1);
        step("pop_full", 1'b0, 1'b0, 1'b1, '0);
        check("popf_s0", 32'(o_s0), 32'd3);
        check("popf_full", 32'(o_full), 32'd0);

        // Reset with a simultaneous push at count 3 and overflow set.
        step("rst_push77", 1'b1, 1'b1, 1'b0, 16'd77);
        check("rp_count", 32'(o_count), 32'd0);
        check("rp_empty", 32'(o_empty), 32'd1);
        check("rp_s0", 32'(o_s0), 32'd0);
        check("rp_ovf", 32'(o_overflow), 32'd0);
        check("rp_unf", 32'(o_underflow), 32'd0);

        // Underflow from empty, replace on empty, then recovery.
        step("pop_empty", 1'b0, 1'b0, 1'b1, '0);
        check("unf_flag", 32'(o_underflow), 32'd1);
        check("unf_count", 32'(o_count), 32'd0);
        step("rep_empty", 1'b0, 1'b1, 1'b1, 16'd9);
        check("repe_empty", 32'(o_empty), 32'd1);
        check("repe_s0", 32'(o_s0), 32'd0);
        step("push9", 1'b0, 1'b1, 1'b0, 16'd9);
        check("p9_s0", 32'(o_s0), 32'd9);
        check("p9_unf", 32'(o_underflow), 32'd1);

        // High-water mark.
        step("reset3", 1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) step("hw_push", 1'b0, 1'b1, 1'b0, 16'(100 + k));
        for (int k = 0; k < 2; k++) step("hw_pop", 1'b0, 1'b0, 1'b1, '0);
        step("hw_push2", 1'b0, 1'b1, 1'b0, 16'd200);
        check("hw_value", 32'(o_hiwater), 32'(HW_EXPECT));

        // Random back-to-back traffic with occasional resets.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            logic       r;
            op = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 19) == 0);
            step("rand", r, op[1], op[0], 16'($urandom_range(0, 65535)));
        end

        i_push = 1'b0;
        i_pop  = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
